// File: rtl/i2c_master_nb.sv
// rtl/i2c_master_nb.sv - multi-byte I2C master: START, addr+R/W, NBYTES data with ACK checking, STOP
// Outputs are registered from next-state values so they line up with the state register.
module i2c_master_nb #(
  parameter int CLK_DIV = 1,
  parameter int NBYTES  = 2
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                START_STB,
  input  logic                RNW,
  input  logic [6:0]          I2C_ADDR,
  input  logic [8*NBYTES-1:0] WR_DATA,
  input  logic                SDA_IN,
  output logic                SCL,
  output logic                SDA_OUT,
  output logic                SDA_OE,
  output logic [8*NBYTES-1:0] RD_DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                NACK
);
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = 8 * NBYTES;
  localparam int SW = DW + 8;

  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qtr_q, qtr_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [DW-1:0] rx_q, rx_d, rd_q, rd_d;
  logic          rnw_q, rnw_d, ack_q, ack_d;
  logic          busy_q, busy_d, done_q, done_d, nack_q, nack_d;
  logic          scl_q, scl_d, sda_out_q, sda_out_d, sda_oe_q, sda_oe_d;
  logic          tick, sample, slot_end;

  assign tick     = (qtr_q == QW'(CLK_DIV - 1));
  assign sample   = tick && (ph_q == 2'd2);
  assign slot_end = tick && (ph_q == 2'd3);

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    rnw_d   = rnw_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nack_d  = nack_q;

    if (state_q != IDLE) begin
      qtr_d = tick ? '0 : qtr_q + 1'b1;
      if (tick) ph_d = ph_q + 2'd1;
    end

    if (sample) begin
      ack_d = SDA_IN;
      if (state_q == DATA && rnw_q) rx_d = {rx_q[DW-2:0], SDA_IN};
    end

    case (state_q)
      IDLE: begin
        if (START_STB) begin
          state_d = START;
          qtr_d   = '0;
          ph_d    = 2'd0;
          bit_d   = 3'd7;
          sh_d    = {I2C_ADDR, RNW, WR_DATA};
          rnw_d   = RNW;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
        end
      end
      START: begin
        if (tick && ph_q == 2'd1) begin
          state_d = ADDR;
          ph_d    = 2'd0;
        end
      end
      ADDR: begin
        if (slot_end) begin
          sh_d = sh_q << 1;
          if (bit_q == 3'd0) state_d = ADDR_ACK;
          else bit_d = bit_q - 3'd1;
        end
      end
      ADDR_ACK: begin
        if (slot_end) begin
          if (ack_q) begin
            state_d = STOP;
            nack_d  = 1'b1;
          end else begin
            state_d = DATA;
            bit_d   = 3'd7;
            byte_d  = 2'(NBYTES - 1);
          end
        end
      end
      DATA: begin
        if (slot_end) begin
          sh_d = sh_q << 1;
          if (bit_q == 3'd0) state_d = DATA_ACK;
          else bit_d = bit_q - 3'd1;
        end
      end
      DATA_ACK: begin
        // Slave NACK only aborts writes; on reads the master owns this slot.
        if (slot_end) begin
          if (!rnw_q && ack_q) begin
            state_d = STOP;
            nack_d  = 1'b1;
          end else if (byte_q == 2'd0) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
            bit_d   = 3'd7;
            byte_d  = byte_q - 2'd1;
          end
        end
      end
      STOP: begin
        if (slot_end) begin
          state_d = IDLE;
          qtr_d   = '0;
          ph_d    = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rnw_q && !nack_q) rd_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scl_d     = 1'b1;
    sda_oe_d  = 1'b0;
    sda_out_d = 1'b1;
    case (state_d)
      START: begin
        sda_oe_d  = ph_d[0];
        sda_out_d = ~ph_d[0];
      end
      ADDR: begin
        scl_d     = ph_d[1];
        sda_oe_d  = 1'b1;
        sda_out_d = sh_d[SW-1];
      end
      ADDR_ACK: scl_d = ph_d[1];
      DATA: begin
        scl_d     = ph_d[1];
        sda_oe_d  = ~rnw_d;
        sda_out_d = rnw_d | sh_d[SW-1];
      end
      DATA_ACK: begin
        scl_d     = ph_d[1];
        sda_oe_d  = rnw_d;
        sda_out_d = ~rnw_d | (byte_d == 2'd0);
      end
      STOP: begin
        scl_d     = (ph_d != 2'd0);
        sda_oe_d  = ~ph_d[1];
        sda_out_d = ph_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= IDLE;
      qtr_q     <= '0;
      ph_q      <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      sh_q      <= '0;
      rx_q      <= '0;
      rd_q      <= '0;
      rnw_q     <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_out_q <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      rd_q      <= rd_d;
      rnw_q     <= rnw_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_out_q <= sda_out_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign SCL     = scl_q;
  assign SDA_OUT = sda_out_q;
  assign SDA_OE  = sda_oe_q;
  assign RD_DATA = rd_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign NACK    = nack_q;

endmodule

// File: tb/tb_i2c_master_nb.sv
// tb/tb_i2c_master_nb.sv - bench for i2c_master_nb (CLK_DIV=1/NBYTES=2 and CLK_DIV=3/NBYTES=1)
// Expected waveforms are built per quarter-period from the protocol rules and checked every cycle.
module tb_i2c_master_nb;
  typedef struct packed {
    logic scl, oe, out, sin, busy, done, nack;
    logic [31:0] rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        RESET;
  logic        stb [2];
  logic        rnw [2];
  logic [6:0]  addr [2];
  logic [15:0] wr0;
  logic [7:0]  wr1;
  logic        sda_in [2];
  logic        scl_w [2], sda_out_w [2], sda_oe_w [2], busy_w [2], done_w [2], nack_w [2];
  logic [15:0] rd0;
  logic [7:0]  rd1;

  ent_t        q0[$], q1[$];
  logic [31:0] model_rd [2];
  logic        model_nack [2];
  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  int          cyc = 0;
  int          busy_t [2] = '{0, 0};
  int          done_lat [2] = '{-1, -1};
  logic        busy_p [2] = '{1'b0, 1'b0};
  logic        scl_p = 1'b1;
  logic [31:0] mon = 32'h0;

  always #5 clk = ~clk;

  i2c_master_nb #(.CLK_DIV(1), .NBYTES(2)) dut0 (
    .clk(clk), .RESET(RESET), .START_STB(stb[0]), .RNW(rnw[0]), .I2C_ADDR(addr[0]),
    .WR_DATA(wr0), .SDA_IN(sda_in[0]), .SCL(scl_w[0]), .SDA_OUT(sda_out_w[0]),
    .SDA_OE(sda_oe_w[0]), .RD_DATA(rd0), .BUSY(busy_w[0]), .DONE(done_w[0]), .NACK(nack_w[0]));

  i2c_master_nb #(.CLK_DIV(3), .NBYTES(1)) dut1 (
    .clk(clk), .RESET(RESET), .START_STB(stb[1]), .RNW(rnw[1]), .I2C_ADDR(addr[1]),
    .WR_DATA(wr1), .SDA_IN(sda_in[1]), .SCL(scl_w[1]), .SDA_OUT(sda_out_w[1]),
    .SDA_OE(sda_oe_w[1]), .RD_DATA(rd1), .BUSY(busy_w[1]), .DONE(done_w[1]), .NACK(nack_w[1]));

  function automatic logic [31:0] rd_of(input int i);
    return (i == 0) ? {16'h0, rd0} : {24'h0, rd1};
  endfunction

  always @(negedge clk) begin
    ent_t ce;
    logic bad;
    if (!chk_en) begin
      sda_in[0] = 1'b1;
      sda_in[1] = 1'b1;
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (i == 0 && q0.size() > 0) ce = q0.pop_front();
        else if (i == 1 && q1.size() > 0) ce = q1.pop_front();
        else begin
          ce.scl = 1'b1; ce.oe = 1'b0; ce.out = 1'b1; ce.sin = 1'b1;
          ce.busy = 1'b0; ce.done = 1'b0; ce.nack = model_nack[i]; ce.rd = model_rd[i];
        end
        bad = (scl_w[i] !== ce.scl) || (sda_oe_w[i] !== ce.oe) ||
              (ce.oe && sda_out_w[i] !== ce.out) || (busy_w[i] !== ce.busy) ||
              (done_w[i] !== ce.done) || (nack_w[i] !== ce.nack) || (rd_of(i) !== ce.rd);
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL cycle_model inst%0d cyc %0d: got scl%b oe%b out%b busy%b done%b nack%b rd=%h, expected scl%b oe%b out%b busy%b done%b nack%b rd=%h",
                   i, cyc, scl_w[i], sda_oe_w[i], sda_out_w[i], busy_w[i], done_w[i], nack_w[i], rd_of(i),
                   ce.scl, ce.oe, ce.out, ce.busy, ce.done, ce.nack, ce.rd);
        end
        sda_in[i] = ce.sin;
        if (busy_w[i] && !busy_p[i]) begin
          busy_t[i]   = cyc;
          done_lat[i] = -1;
          if (i == 0) mon = 32'h0;
        end
        if (done_w[i]) done_lat[i] = cyc - busy_t[i];
        busy_p[i] = busy_w[i];
      end
      // Bits the master drives, captured on each SCL rising edge of instance 0.
      if (!scl_p && scl_w[0] && sda_oe_w[0]) mon = {mon[30:0], sda_out_w[0]};
      scl_p = scl_w[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put(input int i, input logic s, input logic o, input logic d, input logic si, input int n);
    ent_t e;
    e.scl = s; e.oe = o; e.out = d; e.sin = si; e.busy = 1'b1; e.done = 1'b0;
    e.nack = model_nack[i]; e.rd = model_rd[i];
    for (int k = 0; k < n; k++) begin
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic slot(input int i, input logic o, input logic d, input logic si);
    int cd;
    cd = (i == 0) ? 1 : 3;
    put(i, 1'b0, o, d, si, 2 * cd);
    put(i, 1'b1, o, d, si, 2 * cd);
  endtask

  // Drive a request (caller sits just after a negedge) and queue the expected per-cycle waveform.
  task automatic launch(input int i, input logic r, input logic [6:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input logic anack, input int dnack, output int len);
    int cd, nb;
    logic [7:0] ab;
    logic ended;
    ent_t e;
    cd = (i == 0) ? 1 : 3;
    nb = (i == 0) ? 2 : 1;
    stb[i] = 1'b1; rnw[i] = r; addr[i] = a;
    if (i == 0) wr0 = wd[15:0];
    else wr1 = wd[7:0];
    model_nack[i] = 1'b0;
    put(i, 1'b1, 1'b0, 1'b1, 1'b1, cd);
    put(i, 1'b1, 1'b1, 1'b0, 1'b1, cd);
    ab = {a, r};
    for (int k = 7; k >= 0; k--) slot(i, 1'b1, ab[k], 1'b1);
    slot(i, 1'b0, 1'b1, anack);
    ended = anack;
    if (anack) model_nack[i] = 1'b1;
    for (int b = nb - 1; b >= 0 && !ended; b--) begin
      for (int k = 7; k >= 0; k--) begin
        if (r) slot(i, 1'b0, 1'b1, rdv[8*b+k]);
        else slot(i, 1'b1, wd[8*b+k], 1'b1);
      end
      if (r) slot(i, 1'b1, 1'(b == 0), 1'b1);
      else begin
        slot(i, 1'b0, 1'b1, 1'(dnack == b));
        if (dnack == b) begin
          model_nack[i] = 1'b1;
          ended = 1'b1;
        end
      end
    end
    put(i, 1'b0, 1'b1, 1'b0, 1'b1, cd);
    put(i, 1'b1, 1'b1, 1'b0, 1'b1, cd);
    put(i, 1'b1, 1'b0, 1'b1, 1'b1, 2 * cd);
    if (r && !model_nack[i]) model_rd[i] = (i == 0) ? {16'h0, rdv[15:0]} : {24'h0, rdv[7:0]};
    e.scl = 1'b1; e.oe = 1'b0; e.out = 1'b1; e.sin = 1'b1; e.busy = 1'b0; e.done = 1'b1;
    e.nack = model_nack[i]; e.rd = model_rd[i];
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    len = (i == 0) ? q0.size() : q1.size();
  endtask

  // Returns in the DONE cycle when n equals the transaction length.
  task automatic wait_txn(input int i, input int n, input int pulse_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      stb[i] = (k == pulse_at);
      if (k == pulse_at) begin
        addr[i] = 7'($urandom);
        rnw[i]  = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int len, i, nb, dn, pl;
    logic r;
    RESET = 1'b1;
    stb[0] = 1'b0; stb[1] = 1'b0; rnw[0] = 1'b0; rnw[1] = 1'b0;
    addr[0] = 7'h0; addr[1] = 7'h0; wr0 = 16'h0; wr1 = 8'h0;
    model_rd[0] = 32'h0; model_rd[1] = 32'h0; model_nack[0] = 1'b0; model_nack[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_sda_out0", 32'(sda_out_w[0]), 32'd1);
    chk("reset_sda_out1", 32'(sda_out_w[1]), 32'd1);
    chk("reset_scl0", 32'(scl_w[0]), 32'd1);
    chk("reset_rd0", {16'h0, rd0}, 32'h0);
    chk("reset_busy1", 32'(busy_w[1]), 32'd0);
    chk_en = 1'b1;
    RESET = 1'b0;
    idle(2);

    launch(0, 1'b0, 7'h50, 32'hA5C3, 32'h0, 1'b0, -1, len);
    chk("model_len_write", len, 115);
    wait_txn(0, len, -1);
    chk("write_latency", done_lat[0], 114);
    chk("write_sda_bits", mon & 32'h01FF_FFFF, {7'h0, 24'hA0A5C3, 1'b0});
    chk("write_nack", 32'(nack_w[0]), 32'd0);

    // Started in the DONE cycle, with an ignored request in the middle.
    launch(0, 1'b1, 7'h50, 32'h0, 32'h3C81, 1'b0, -1, len);
    wait_txn(0, len, 40);
    chk("read_latency", done_lat[0], 114);
    chk("read_rd_data", {16'h0, rd0}, 32'h3C81);
    chk("read_sda_bits", mon & 32'h7FF, 32'h50A);

    idle(3);
    launch(0, 1'b0, 7'h2A, 32'h1234, 32'h0, 1'b1, -1, len);
    chk("model_len_addr_nack", len, 43);
    wait_txn(0, len, -1);
    chk("addr_nack_latency", done_lat[0], 42);
    chk("addr_nack_flag", 32'(nack_w[0]), 32'd1);
    chk("addr_nack_rd_kept", {16'h0, rd0}, 32'h3C81);

    idle(2);
    launch(1, 1'b0, 7'h11, 32'h5A, 32'h0, 1'b0, -1, len);
    chk("model_len_div3", len, 235);
    wait_txn(1, len, -1);
    chk("div3_latency", done_lat[1], 234);

    idle(2);
    launch(0, 1'b0, 7'h33, 32'hBEEF, 32'h0, 1'b0, -1, len);
    wait_txn(0, 60, -1);
    RESET = 1'b1;
    q0.delete(); q1.delete();
    model_rd[0] = 32'h0; model_rd[1] = 32'h0; model_nack[0] = 1'b0; model_nack[1] = 1'b0;
    idle(1);
    RESET = 1'b0;
    chk("mid_reset_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_reset_oe", 32'(sda_oe_w[0]), 32'd0);
    launch(0, 1'b0, 7'h33, 32'hBEEF, 32'h0, 1'b0, -1, len);
    wait_txn(0, len, -1);
    chk("after_reset_latency", done_lat[0], 114);

    for (int t = 0; t < 30; t++) begin
      i  = int'($urandom_range(0, 1));
      nb = (i == 0) ? 2 : 1;
      r  = 1'($urandom);
      dn = (!r && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      launch(i, r, 7'($urandom), $urandom, $urandom, 1'($urandom_range(0, 5) == 0), dn, len);
      pl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, len - 5)) : -1;
      wait_txn(i, len, pl);
      idle(int'($urandom_range(0, 2)));
    end

    idle(5);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_nb.md
# i2c_master_nb

Parametrised I2C master controller, the multi-byte, clock-divided generation of the team's I2C generator block. One START_STB launches a complete transaction: START, 7-bit address plus R/W bit, NBYTES data bytes written or read, and STOP. It adds a programmable SCL rate, real ACK/NACK checking with abort, master ACK/NACK on reads, and BUSY/DONE/NACK status. It sits between the register/control logic and the SDA/SCL pad drivers.

## Interface
- CLK_DIV, default 1: clk cycles per SCL quarter-period (>=1); SCL period = 4*CLK_DIV clk.
- NBYTES, default 2: data bytes per transaction (1..4).
- clk  in  1  system clock; all logic on posedge.
- RESET  in  1  reset, synchronous, active-high; clock clk.
- START_STB  in  1  one-cycle transaction request; honoured only when BUSY=0.
- RNW  in  1  1 = read, 0 = write; latched at accept.
- I2C_ADDR  in  7  slave address; latched at accept.
- WR_DATA  in  8*NBYTES  write payload; latched at accept.
- SDA_IN  in  1  sampled SDA line.
- SCL  out  1  serial clock (registered).
- SDA_OUT  out  1  SDA drive value; meaningful only when SDA_OE=1.
- SDA_OE  out  1  1 = master drives SDA; 0 = released.
- RD_DATA  out  8*NBYTES  read payload; updated only on a completed read.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle pulse at end of every transaction, including aborted ones.
- NACK  out  1  last transaction aborted on NACK; held until the next accept.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- Quarter counter runs 0..CLK_DIV-1. Phase counter q runs 0..3 per bit. Bit counter runs 7..0. Byte counter runs NBYTES-1..0.
- IDLE: SCL=1, SDA_OE=0. When START_STB=1, latch RNW, I2C_ADDR and WR_DATA, set BUSY=1, clear NACK, go to START.
- START (2 quarters, SCL=1): q0 SDA_OE=0; q1 SDA_OE=1, SDA_OUT=0.
- Bit slot (ADDR/DATA/ACK, 4 quarters each): SCL=0 in q0-q1 and SCL=1 in q2-q3. SDA outputs change only at q0 entry. SDA_IN is sampled on the last clk of q2.
- ADDR: shift {I2C_ADDR,RNW} MSB first, driven (SDA_OE=1).
- ADDR_ACK: SDA_OE=0.
  - SDA_IN=0: go to DATA.
  - SDA_IN=1: set NACK=1 and go to STOP.
- DATA, write: drive WR_DATA MSB first. Highest byte [8*NBYTES-1 -: 8] goes first.
- DATA, read: SDA_OE=0. Shift the sample into a holding register MSB first, highest byte first.
- DATA_ACK, write: SDA_OE=0.
  - SDA_IN=1: set NACK=1 and go to STOP.
  - SDA_IN=0 with more bytes left: go to DATA.
  - SDA_IN=0 on the last byte: go to STOP.
- DATA_ACK, read: SDA_OE=1. SDA_OUT=0 (ACK) except on the last byte, where SDA_OUT=1 (NACK).
- STOP (4 quarters): q0 SCL=0, SDA_OE=1, SDA_OUT=0; q1 SCL=1, SDA 0; q2-q3 SCL=1, SDA_OE=0.
- End of STOP: go to IDLE, BUSY=0, DONE=1 for one cycle. On a read without NACK, RD_DATA is loaded from the holding register in the same cycle.
- START_STB while BUSY=1: ignored, not queued.
- START_STB in the DONE cycle: accepted (BUSY is already 0).

## Timing
- Reset values: SCL=1, SDA_OUT=1, SDA_OE=0, RD_DATA=0, BUSY=0, DONE=0, NACK=0. Internal state is IDLE with all counters cleared.
- RESET mid-transaction: outputs take reset values at the next edge. No STOP is generated and no DONE is pulsed.
- BUSY rises on the clk edge after START_STB is sampled. The START q0 begins in that same cycle.
- Full transaction length from BUSY rise to DONE = CLK_DIV*(2 + 36*(1+NBYTES) + 4) cycles. For NBYTES=2, CLK_DIV=1 this is 114.
- Aborted on address NACK: CLK_DIV*(2+36+4) cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- NACK and RD_DATA are stable from the DONE cycle until the next accept.

## Test plan
- Write, CLK_DIV=1, NBYTES=2, addr 0x50, WR_DATA 0xA5C3, slave ACKs all slots:
  - SDA bytes are 0xA0, 0xA5, 0xC3, MSB first, each with SDA_OE=0 in the ACK slot.
  - DONE is asserted 114 cycles after BUSY rises; NACK=0.
- Read, addr 0x50, slave returns 0x3C then 0x81:
  - Address byte 0xA1.
  - Master ACK slot after byte 1 has SDA_OE=1, SDA_OUT=0; NACK slot after byte 2 has SDA_OUT=1.
  - RD_DATA=0x3C81 at DONE.
- Address NACK (SDA_IN=1 in ADDR_ACK):
  - STOP follows immediately; DONE at 42 cycles; NACK=1.
  - RD_DATA is unchanged.
- CLK_DIV=3, NBYTES=1 write:
  - SCL high and low each last 6 clk.
  - Transaction takes 3*(2+72+4)=234 cycles.
- START_STB pulsed mid-transaction: ignored, with no change in the bit stream. START_STB in the DONE cycle starts a new transaction the next cycle.
- RESET asserted during DATA: next cycle SCL=1, SDA_OE=0, BUSY=0, with no DONE pulse. A following START_STB runs a normal transaction.
